seq_mult_acc: RTL and testbench
===============================

Name: seq_mult_acc

Overview:
- Parametrised sequential multiply-accumulate unit; next generation of the 2-bit adder stage.
- Computes product = a*b + addend + cin over multiple clocks.
- Retires STEP multiplier bits per cycle through one shared adder stage, instead of a fully combinational array.
- Used as the arithmetic core wherever an area-cheap multiplier with start/done handshake is needed.

Parameters:
WIDTH, 8, operand width of a, b and addend; must be a multiple of STEP, minimum 2.
STEP, 2, multiplier bits retired per cycle; legal values 1, 2, 4.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only in IDLE or DONE.
a  input  WIDTH  multiplicand (unsigned), captured when start is accepted.
b  input  WIDTH  multiplier (unsigned), captured when start is accepted.
addend  input  WIDTH  unsigned value added to the product, captured when start is accepted.
cin  input  1  carry-in added to the product, captured when start is accepted.
busy  output  1  high while the computation is running (state RUN).
done  output  1  one-cycle pulse; product is valid on and after it.
product  output  2*WIDTH  result register.

Behaviour:
- Reset value of every output:
  - rst asserted (any time, asynchronously) → state IDLE, busy=0, done=0, product=0.
  - Internal registers (a_r, b_r, acc, count) are cleared.
- N = WIDTH/STEP computation cycles.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 at edge E0 → capture a_r=a, b_r=b, acc={WIDTH'b0, addend} + cin, count=0; go to RUN. start=0 → stay.
  - RUN: each edge performs acc = acc + ((a_r * b_r[STEP*count +: STEP]) << (STEP*count)); count++.
  - RUN: at the edge performing step count=N-1, go to DONE and load product with the final acc value.
  - DONE: lasts exactly one cycle. start=1 → behave as IDLE accept (back-to-back, no bubble). Otherwise → IDLE.
- Timing:
  - busy=1 from E0 until edge E0+N.
  - done=1 for the cycle between E0+N and E0+N+1.
  - Total latency is N edges from the start edge.
- start while in RUN is ignored: operands are not re-captured and there is no error indication.
- Width rules:
  - All arithmetic is unsigned. The per-step partial product is WIDTH+STEP bits, added into a 2*WIDTH accumulator.
  - Maximum result (2^W-1)^2 + 2^W = 2^2W - 2^W + 1 fits in 2*WIDTH bits, so overflow is impossible and no carry-out is needed.
- product holds its last value through IDLE and RUN; it changes only at completion or reset.
- Input changes after start is accepted have no effect on the running computation.
- Reset mid-RUN: the operation is abandoned and done never pulses for it. The first start after rst deasserts is accepted normally.
- Illegal parameters (WIDTH % STEP != 0, STEP not in {1,2,4}): elaboration-time error via generate check.

Test Plan:
- Full-scale: WIDTH=8, STEP=2; a=255, b=255, addend=255, cin=1, start pulse → busy high 4 cycles; done pulses 4 edges after the start edge; product=16'hFF01 (65281).
- Addend pass-through: a=0, b=173, addend=200, cin=1 → product=201. a=12, b=0, addend=0, cin=0 → product=0. Both with done after 4 cycles.
- Ignore-while-busy and back-to-back:
  - Start a=3, b=5 (addend=0, cin=0); pulse start again in cycle 2 with a=9, b=9 → single done, product=15.
  - Then hold start=1 during the DONE cycle with a=10, b=10 → next done exactly 4 cycles later, product=100; busy has no idle gap.
- Reset mid-operation: start a=200, b=100; assert rst in cycle 2 (between edges) → busy, done and product go to 0 immediately; no done pulse follows. After release, a=7, b=6 → product=42.
- STEP variant: WIDTH=4, STEP=1; a=13, b=11, addend=2, cin=0 → busy 4 cycles, product=8'd145.
- STEP variant: WIDTH=8, STEP=4; a=200, b=150, addend=0, cin=1 → busy 2 cycles, product=30001.
- Random regression: 1000 random vectors per configuration, compared against a*b+addend+cin.

Source files
------------

// File: rtl/seq_mult_acc.sv
// Sequential multiply-accumulate: product = a*b + addend + cin.
// Retires STEP multiplier bits per clock through one shared adder, with a start/busy/done handshake.
module seq_mult_acc #(
    parameter int WIDTH = 8,
    parameter int STEP  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   addend,
    input  logic               cin,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if ((WIDTH % STEP) != 0 || WIDTH < 2 || !(STEP == 1 || STEP == 2 || STEP == 4)) begin : g_bad_params
            $error("seq_mult_acc: WIDTH must be a multiple of STEP (>= 2) and STEP must be 1, 2 or 4");
        end
    endgenerate

    logic [1:0]           state;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        count;

    logic [STEP-1:0]       digit;
    logic [WIDTH+STEP-1:0] partial;
    logic [2*WIDTH-1:0]    acc_next;
    logic                  last;

    // NOTE: every signal gets a value on every path through always_comb, so no latch can be inferred.
    always_comb begin
        digit    = b_r[int'(count)*STEP +: STEP];
        partial  = {{STEP{1'b0}}, a_r} * {{WIDTH{1'b0}}, digit};
        acc_next = acc + ((2*WIDTH)'(partial) << (int'(count)*STEP));
        last     = (count == CW'(N-1));
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            acc     <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // DONE accepts a new start directly, giving back-to-back operation without a bubble.
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        acc   <= (2*WIDTH)'(addend) + (2*WIDTH)'(cin);
                        count <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    count <= count + CW'(1);
                    if (last) begin
                        product <= acc_next;
                        state   <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_acc.sv
// Bench for seq_mult_acc: three configurations (8/2, 4/1, 8/4) checked every cycle
// against a transaction-level model, plus directed literal cases and a random regression.
module tb_seq_mult_acc;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start_v [3];
    logic [7:0] a_v     [3];
    logic [7:0] b_v     [3];
    logic [7:0] ad_v    [3];
    logic       cin_v   [3];

    logic        busy0, busy1, busy2, done0, done1, done2;
    logic [15:0] prod0, prod2;
    logic [7:0]  prod1;

    logic        busy_v [3];
    logic        done_v [3];
    logic [15:0] prod_v [3];

    int w_arr [3] = '{8, 4, 8};
    int n_arr [3] = '{4, 4, 2};

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level model: edges left before the result, pending result, visible result.
    int          rem    [3] = '{0, 0, 0};
    logic        done_m [3] = '{1'b0, 1'b0, 1'b0};
    logic [15:0] prod_m [3] = '{16'h0, 16'h0, 16'h0};
    logic [15:0] pend   [3];
    int          ops    [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    seq_mult_acc #(.WIDTH(8), .STEP(2)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
        .addend(ad_v[0]), .cin(cin_v[0]), .busy(busy0), .done(done0), .product(prod0));

    seq_mult_acc #(.WIDTH(4), .STEP(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1][3:0]), .b(b_v[1][3:0]),
        .addend(ad_v[1][3:0]), .cin(cin_v[1]), .busy(busy1), .done(done1), .product(prod1));

    seq_mult_acc #(.WIDTH(8), .STEP(4)) dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
        .addend(ad_v[2]), .cin(cin_v[2]), .busy(busy2), .done(done2), .product(prod2));

    always_comb begin
        busy_v[0] = busy0;
        busy_v[1] = busy1;
        busy_v[2] = busy2;
        done_v[0] = done0;
        done_v[1] = done1;
        done_v[2] = done2;
        prod_v[0] = prod0;
        prod_v[1] = {8'h00, prod1};
        prod_v[2] = prod2;
    end

    function automatic logic [15:0] mac(input int i, input logic [7:0] aa, input logic [7:0] bb,
                                        input logic [7:0] ad, input logic c);
        int m;
        m = (1 << w_arr[i]) - 1;
        return 16'((int'(aa) & m) * (int'(bb) & m) + (int'(ad) & m) + int'(c));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                rem[i]    <= 0;
                done_m[i] <= 1'b0;
                prod_m[i] <= 16'h0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (rem[i] > 0) begin
                    rem[i]    <= rem[i] - 1;
                    done_m[i] <= (rem[i] == 1);
                    if (rem[i] == 1) begin
                        prod_m[i] <= pend[i];
                        ops[i]    <= ops[i] + 1;
                    end
                end else begin
                    done_m[i] <= 1'b0;
                    if (start_v[i]) begin
                        pend[i] <= mac(i, a_v[i], b_v[i], ad_v[i], cin_v[i]);
                        rem[i]  <= n_arr[i];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            check($sformatf("busy[%0d]", i), 32'(busy_v[i]), 32'(rem[i] > 0));
            check($sformatf("done[%0d]", i), 32'(done_v[i]), 32'(done_m[i]));
            check($sformatf("product[%0d]", i), 32'(prod_v[i]), 32'(prod_m[i]));
        end
    end

    task automatic drive(input int i, input logic [7:0] aa, input logic [7:0] bb,
                         input logic [7:0] ad, input logic c);
        a_v[i]     = aa;
        b_v[i]     = bb;
        ad_v[i]    = ad;
        cin_v[i]   = c;
        start_v[i] = 1'b1;
    endtask

    // Counts negedges from the call until done is seen; start is dropped after the first one.
    task automatic wait_done(input int i, output int n);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            start_v[i] = 1'b0;
            if (done_v[i]) return;
        end
        check($sformatf("done_timeout[%0d]", i), 32'(done_v[i]), 32'd1);
    endtask

    task automatic run_op(input int i, input logic [7:0] aa, input logic [7:0] bb,
                          input logic [7:0] ad, input logic c, input logic [15:0] exp);
        int n;
        drive(i, aa, bb, ad, c);
        wait_done(i, n);
        check($sformatf("latency[%0d]", i), 32'(n - 1), 32'(n_arr[i]));
        check($sformatf("lit_product[%0d]", i), 32'(prod_v[i]), 32'(exp));
        check($sformatf("lit_model[%0d]", i), 32'(prod_m[i]), 32'(exp));
    endtask

    initial begin
        int n;
        int cyc;
        int base [3];
        logic pending;

        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            a_v[i]     = 8'h0;
            b_v[i]     = 8'h0;
            ad_v[i]    = 8'h0;
            cin_v[i]   = 1'b0;
        end

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(busy0), 32'd0);
        check("reset_done", 32'(done0), 32'd0);
        check("reset_product", 32'(prod0), 32'd0);

        run_op(0, 8'd255, 8'd255, 8'd255, 1'b1, 16'hFF01);
        run_op(0, 8'd0, 8'd173, 8'd200, 1'b1, 16'd201);
        run_op(0, 8'd12, 8'd0, 8'd0, 1'b0, 16'd0);

        // Second start while running must be ignored.
        drive(0, 8'd3, 8'd5, 8'd0, 1'b0);
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        drive(0, 8'd9, 8'd9, 8'd0, 1'b0);
        wait_done(0, n);
        check("ignore_latency", 32'(n), 32'd3);
        check("ignore_product", 32'(prod0), 32'd15);

        // Start held during the DONE cycle: back-to-back with no idle gap.
        drive(0, 8'd10, 8'd10, 8'd0, 1'b0);
        @(negedge clk);
        start_v[0] = 1'b0;
        check("b2b_no_gap", 32'(busy0), 32'd1);
        wait_done(0, n);
        check("b2b_latency", 32'(n), 32'd4);
        check("b2b_product", 32'(prod0), 32'd100);

        // Reset in the middle of an operation.
        drive(0, 8'd200, 8'd100, 8'd0, 1'b0);
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        check("pre_reset_busy", 32'(busy0), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_busy", 32'(busy0), 32'd0);
        check("async_done", 32'(done0), 32'd0);
        check("async_product", 32'(prod0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("no_done_after_reset", 32'(done0), 32'd0);
        end
        run_op(0, 8'd7, 8'd6, 8'd0, 1'b0, 16'd42);

        run_op(1, 8'd13, 8'd11, 8'd2, 1'b0, 16'd145);
        run_op(2, 8'd200, 8'd150, 8'd0, 1'b1, 16'd30001);

        // Random regression on all three configurations at once.
        for (int i = 0; i < 3; i++) base[i] = ops[i];
        cyc = 0;
        pending = 1'b1;
        while (pending && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 3; i++) begin
                start_v[i] = ($urandom_range(3) != 0);
                if ($urandom_range(7) == 0) begin
                    a_v[i]  = 8'hFF;
                    b_v[i]  = 8'hFF;
                    ad_v[i] = 8'hFF;
                    cin_v[i] = 1'b1;
                end else begin
                    a_v[i]   = 8'($urandom);
                    b_v[i]   = 8'($urandom);
                    ad_v[i]  = 8'($urandom);
                    cin_v[i] = 1'($urandom);
                end
            end
            pending = 1'b0;
            for (int i = 0; i < 3; i++)
                if (ops[i] - base[i] < 1000) pending = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            check($sformatf("random_ops[%0d]", i), 32'(ops[i] - base[i] >= 1000), 32'd1);
        end
        repeat (8) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
